io_bank_ctrl: RTL and testbench

IO_BANK_CTRL -- requirements
Module: io_bank_ctrl

---
 rtl/io_bank_ctrl.sv | 167 ++++++++++++++++
 tb/tb_io_bank_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/io_bank_ctrl.sv
// Banked GPIO controller: masked writes, synchronized reads, timed pulses.
// Define IO_PULSE_EN to build the pulse engine; otherwise opcode 10 errors.
module io_bank_ctrl #(
  parameter int N_BANK     = 3,
  parameter int IO_NBIT    = 8,
  parameter int BANK_NBIT  = 2,
  parameter int PULSE_NBIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_vd,
  output logic                      cmd_rdy,
  input  logic [1:0]                cmd_op,
  input  logic [BANK_NBIT-1:0]      cmd_bank,
  input  logic [IO_NBIT-1:0]        cmd_mask,
  input  logic [IO_NBIT-1:0]        cmd_dir,
  input  logic [IO_NBIT-1:0]        cmd_db,
  input  logic [PULSE_NBIT-1:0]     cmd_len,
  input  logic [N_BANK*IO_NBIT-1:0] io_i,
  output logic [N_BANK*IO_NBIT-1:0] io_o,
  output logic [N_BANK*IO_NBIT-1:0] io_oe,
  output logic                      rd_vd,
  output logic [IO_NBIT-1:0]        rd_data,
  output logic                      err
);

  localparam int W = N_BANK * IO_NBIT;
  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_PL = 2'b10;

  logic [W-1:0] sync1, sync2;
  logic [W-1:0] dir_q, db_q;
  logic [IO_NBIT-1:0] rd_sel;
  logic acc, bank_ok, is_wr, is_rd, bad, idle;

  assign io_o    = db_q;
  assign io_oe   = dir_q;
  assign cmd_rdy = ~rst & idle;
  assign acc     = cmd_vd & cmd_rdy;
  assign bank_ok = int'(cmd_bank) < N_BANK;
  assign is_wr   = acc & bank_ok & (cmd_op == OP_WR);
  assign is_rd   = acc & (cmd_op == OP_RD);

  always_comb begin
    rd_sel = '0;
    for (int b = 0; b < N_BANK; b++)
      if (int'(cmd_bank) == b)
        rd_sel = sync2[b*IO_NBIT +: IO_NBIT];
  end

`ifdef IO_PULSE_EN
  typedef enum logic {IDLE, PULSE} state_t;

  state_t state_q, state_d;
  logic [PULSE_NBIT-1:0] cnt_q, cnt_d;
  logic [IO_NBIT-1:0] sv_dir, sv_db, cur_dir, cur_db;
  logic [BANK_NBIT-1:0] sv_bank;
  logic go, restore;

  assign idle = (state_q == IDLE);
  assign go   = acc & bank_ok & (cmd_op == OP_PL);
  assign bad  = acc & (~bank_ok | (cmd_op == 2'b11));

  always_comb begin
    cur_dir = '0;
    cur_db  = '0;
    for (int b = 0; b < N_BANK; b++)
      if (int'(cmd_bank) == b) begin
        cur_dir = dir_q[b*IO_NBIT +: IO_NBIT];
        cur_db  = db_q[b*IO_NBIT +: IO_NBIT];
      end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    restore = 1'b0;
    unique case (state_q)
      IDLE:
        if (go) begin
          state_d = PULSE;
          cnt_d   = (cmd_len == '0) ? PULSE_NBIT'(1) : cmd_len;
        end
      PULSE:
        if (cnt_q <= PULSE_NBIT'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          restore = 1'b1;
        end else begin
          cnt_d = cnt_q - PULSE_NBIT'(1);
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sv_dir  <= '0;
      sv_db   <= '0;
      sv_bank <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (go) begin
        sv_dir  <= cur_dir;
        sv_db   <= cur_db;
        sv_bank <= cmd_bank;
      end
    end
  end
`else
  logic unused_len;

  assign unused_len = ^cmd_len;
  assign idle       = 1'b1;
  assign bad        = acc & (~bank_ok | (cmd_op == 2'b11) |
                             (cmd_op == OP_PL));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      dir_q <= '0;
      db_q  <= '0;
    end else begin
      sync1 <= io_i;
      sync2 <= sync1;
      for (int b = 0; b < N_BANK; b++) begin
        if (is_wr && int'(cmd_bank) == b) begin
          dir_q[b*IO_NBIT +: IO_NBIT] <=
            (dir_q[b*IO_NBIT +: IO_NBIT] & ~cmd_mask) | (cmd_dir & cmd_mask);
          db_q[b*IO_NBIT +: IO_NBIT] <=
            (db_q[b*IO_NBIT +: IO_NBIT] & ~cmd_mask) | (cmd_db & cmd_mask);
        end
`ifdef IO_PULSE_EN
        // Masked pins are forced to drive for the pulse; whole bank is restored.
        if (go && int'(cmd_bank) == b) begin
          dir_q[b*IO_NBIT +: IO_NBIT] <= cur_dir | cmd_mask;
          db_q[b*IO_NBIT +: IO_NBIT]  <=
            (cur_db & ~cmd_mask) | (cmd_db & cmd_mask);
        end
        if (restore && int'(sv_bank) == b) begin
          dir_q[b*IO_NBIT +: IO_NBIT] <= sv_dir;
          db_q[b*IO_NBIT +: IO_NBIT]  <= sv_db;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vd   <= 1'b0;
      rd_data <= '0;
      err     <= 1'b0;
    end else begin
      rd_vd   <= is_rd;
      rd_data <= (is_rd && bank_ok) ? rd_sel : '0;
      err     <= bad;
    end
  end

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Directed self-checking bench for io_bank_ctrl (default parameters).
module tb_io_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vd;
  logic        cmd_rdy;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_bank;
  logic [7:0]  cmd_mask, cmd_dir, cmd_db;
  logic [15:0] cmd_len;
  logic [23:0] io_i, io_o, io_oe;
  logic        rd_vd;
  logic [7:0]  rd_data;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  io_bank_ctrl dut (
    .clk(clk), .rst(rst), .cmd_vd(cmd_vd), .cmd_rdy(cmd_rdy),
    .cmd_op(cmd_op), .cmd_bank(cmd_bank), .cmd_mask(cmd_mask),
    .cmd_dir(cmd_dir), .cmd_db(cmd_db), .cmd_len(cmd_len),
    .io_i(io_i), .io_o(io_o), .io_oe(io_oe),
    .rd_vd(rd_vd), .rd_data(rd_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] bank,
                     input logic [7:0] mask, input logic [7:0] dir,
                     input logic [7:0] db, input logic [15:0] len);
    cmd_vd = 1'b1; cmd_op = op; cmd_bank = bank;
    cmd_mask = mask; cmd_dir = dir; cmd_db = db; cmd_len = len;
  endtask

  initial begin
    rst = 1'b1;
    io_i = '0;
    cmd(2'b00, 2'd0, 8'hFF, 8'hFF, 8'hFF, 16'd0);
    step();
    step();
    chk("rst_oe", io_oe, 24'h0);
    chk("rst_o", io_o, 24'h0);
    chk("rst_rdy", cmd_rdy, 1'b0);
    chk("rst_rdvd", rd_vd, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    cmd_vd = 1'b0;
    #1;
    chk("rdy_after_rst", cmd_rdy, 1'b1);

    cmd(2'b00, 2'd1, 8'hFF, 8'h0F, 8'hA5, 16'd0);
    step();
    cmd_vd = 1'b0;
    chk("wr_oe", io_oe, 24'h000F00);
    chk("wr_o", io_o, 24'h00A500);
    chk("wr_err", err, 1'b0);

    cmd(2'b00, 2'd1, 8'hF0, 8'hFF, 8'h00, 16'd0);
    step();
    cmd_vd = 1'b0;
    chk("mask_oe", io_oe, 24'h00FF00);
    chk("mask_o", io_o, 24'h000500);

    io_i = 24'h3C0000;
    step(); step(); step();
    cmd(2'b01, 2'd2, 8'h00, 8'h00, 8'h00, 16'd0);
    step();
    cmd_vd = 1'b0;
    chk("rd_vd", rd_vd, 1'b1);
    chk("rd_data", rd_data, 8'h3C);
    chk("rd_err", err, 1'b0);
    step();
    chk("rd_vd_drop", rd_vd, 1'b0);

    cmd(2'b01, 2'd3, 8'h00, 8'h00, 8'h00, 16'd0);
    step();
    cmd_vd = 1'b0;
    chk("rd3_err", err, 1'b1);
    chk("rd3_vd", rd_vd, 1'b1);
    chk("rd3_data", rd_data, 8'h00);
    step();
    chk("rd3_err_drop", err, 1'b0);

    cmd(2'b11, 2'd0, 8'hFF, 8'hFF, 8'hFF, 16'd0);
    step();
    cmd_vd = 1'b0;
    chk("op11_err", err, 1'b1);
    chk("op11_rdvd", rd_vd, 1'b0);
    chk("op11_oe", io_oe, 24'h00FF00);
    chk("op11_o", io_o, 24'h000500);

    cmd(2'b00, 2'd3, 8'hFF, 8'hFF, 8'hFF, 16'd0);
    step();
    cmd_vd = 1'b0;
    chk("wr3_err", err, 1'b1);
    chk("wr3_oe", io_oe, 24'h00FF00);

`ifdef IO_PULSE_EN
    cmd(2'b10, 2'd0, 8'h01, 8'h00, 8'h01, 16'd5);
    step();
    cmd_vd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pl_oe", io_oe[0], 1'b1);
      chk("pl_o", io_o[0], 1'b1);
      chk("pl_rdy", cmd_rdy, 1'b0);
      step();
    end
    chk("pl_rest_oe", io_oe, 24'h00FF00);
    chk("pl_rest_o", io_o, 24'h000500);
    chk("pl_rest_rdy", cmd_rdy, 1'b1);

    cmd(2'b10, 2'd0, 8'h01, 8'h00, 8'h01, 16'd0);
    step();
    chk("p0_oe", io_oe[0], 1'b1);
    chk("p0_rdy", cmd_rdy, 1'b0);
    cmd(2'b00, 2'd0, 8'h02, 8'h02, 8'h02, 16'd0);
    step();
    chk("p0_rest_oe", io_oe[7:0], 8'h00);
    chk("p0_wr_stall", io_o[7:0], 8'h00);
    step();
    cmd_vd = 1'b0;
    chk("p0_wr_oe", io_oe[7:0], 8'h02);
    chk("p0_wr_o", io_o[7:0], 8'h02);

    cmd(2'b10, 2'd2, 8'hFF, 8'h00, 8'hFF, 16'd10);
    step();
    cmd_vd = 1'b0;
    chk("p10_oe", io_oe[23:16], 8'hFF);
    step();
    rst = 1'b1;
    step();
    chk("p10_rst_oe", io_oe, 24'h0);
    chk("p10_rst_o", io_o, 24'h0);
    rst = 1'b0;
    #1;
    chk("p10_rdy", cmd_rdy, 1'b1);
    step();
    chk("p10_no_restore", io_oe, 24'h0);
`else
    cmd(2'b10, 2'd0, 8'h01, 8'h00, 8'h01, 16'd5);
    step();
    cmd_vd = 1'b0;
    chk("pl_err", err, 1'b1);
    chk("pl_oe", io_oe, 24'h00FF00);
    chk("pl_rdy", cmd_rdy, 1'b1);

    rst = 1'b1;
    step();
    chk("rst2_oe", io_oe, 24'h0);
    chk("rst2_rdy", cmd_rdy, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst2_rdy_up", cmd_rdy, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
